// File: rtl/activation_scheduler.sv
// Round-robin scheduler sharing one ReLU + requantize + saturate datapath across accumulator lanes.
// Optional leaky ReLU (slope 1/8) when ACT_LEAKY_RELU_EN is defined; plain ReLU otherwise.
module activation_scheduler #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [CNT_WIDTH-1:0]              cfg_num_outputs,
  input  logic [NUM_LANES-1:0]              lane_valid,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   lane_data,
  output logic [NUM_LANES-1:0]              lane_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_LANES)-1:0]      out_lane,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned LW = $clog2(NUM_LANES);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   r_target;
  logic [LW-1:0]          r_rr;
  logic                   r_out_valid;
  logic [OUT_WIDTH-1:0]   r_out_data;
  logic [LW-1:0]          r_out_lane;
  logic                   r_busy;
  logic                   r_done;

  logic [DATA_WIDTH-1:0]  w_lane [NUM_LANES];
  logic                   w_found;
  logic [LW-1:0]          w_grant;
  logic [LW-1:0]          w_idx;
  logic                   w_can_accept;
  logic                   w_fire;
  logic signed [DATA_WIDTH-1:0] w_din;
  logic signed [DATA_WIDTH-1:0] w_act;
  logic signed [DATA_WIDTH-1:0] w_shr;
  logic [OUT_WIDTH-1:0]   w_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_unpack
    assign w_lane[i] = lane_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requesting lane at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      w_idx = r_rr + LW'(i);
      if (!w_found && lane_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_can_accept = !r_out_valid || out_ready;
  assign w_fire       = (r_state == S_RUN) && w_can_accept && (r_count < r_target) && w_found;
  assign lane_ready   = w_fire ? (NUM_LANES'(1) << w_grant) : '0;

  // Activation, arithmetic requantize shift, then clamp to the output range.
  always_comb begin
    w_din = $signed(w_lane[w_grant]);
`ifdef ACT_LEAKY_RELU_EN
    w_act = w_din[DATA_WIDTH-1] ? (w_din >>> 3) : w_din;
`else
    w_act = w_din[DATA_WIDTH-1] ? '0 : w_din;
`endif
    w_shr = w_act >>> SHIFT;
    if (w_shr > SAT_MAX) begin
      w_q = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (w_shr < SAT_MIN) begin
      w_q = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      w_q = w_shr[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_target    <= '0;
      r_rr        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Load and drain in one cycle keeps throughput at one result per clock.
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_q;
        r_out_lane  <= w_grant;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target <= cfg_num_outputs;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= (cfg_num_outputs == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_fire) begin
            r_count <= r_count + CNT_WIDTH'(1);
            r_rr    <= w_grant + LW'(1);
            if (r_count + CNT_WIDTH'(1) == r_target) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!r_out_valid || out_ready) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_lane  = r_out_lane;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_activation_scheduler.sv
// Randomized and directed bench for activation_scheduler against a transaction-level reference model.
module tb_activation_scheduler;

  localparam int N  = 4;
  localparam int DW = 24;
  localparam int OW = 8;
  localparam int SH = 8;
  localparam int CW = 16;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CW-1:0]     cfg_num_outputs;
  logic [N-1:0]      lane_valid;
  logic [N*DW-1:0]   lane_data;
  logic [N-1:0]      lane_ready;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic [LW-1:0]     out_lane;
  logic              busy;
  logic              done;

  activation_scheduler #(
    .NUM_LANES(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .SHIFT(SH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_outputs(cfg_num_outputs),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: layer progress, pending output and round-robin pointer.
  bit          m_busy, m_run, m_done, m_pend, m_ovalid;
  int          m_count, m_target, m_rr, m_olane;
  logic [OW-1:0] m_odata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  function automatic int act_ref(input int v);
    int a;
    a = v;
    if (a < 0) begin
`ifdef ACT_LEAKY_RELU_EN
      a = floor_div(a, 8);
`else
      a = 0;
`endif
    end
    a = floor_div(a, 1 << SH);
    if (a > 127) a = 127;
    if (a < -128) a = -128;
    return a;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_run = 0; m_done = 0; m_pend = 0; m_ovalid = 0;
    m_count = 0; m_target = 0; m_rr = 0; m_olane = 0; m_odata = '0;
  endtask

  // Check DUT against the model mid-cycle, then advance the model across the next edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int  g;
    int  v;
    bit  pop;
    bit  nd;
    bit  old_busy;
    @(negedge clk);
    g = -1;
    if (m_run && m_count < m_target && (!m_ovalid || out_ready)) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && lane_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check_eq("lane_ready", 32'(lane_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(m_ovalid));
    if (m_ovalid) begin
      check_eq("out_data", 32'(out_data), 32'(m_odata));
      check_eq("out_lane", 32'(out_lane), 32'(m_olane));
    end
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));

    old_busy = m_busy;
    pop = m_ovalid && out_ready;
    nd  = m_pend;
    m_pend = 0;
    if (g >= 0) begin
      v = $signed(lane_data[g*DW +: DW]);
      m_ovalid = 1;
      m_odata  = OW'(act_ref(v));
      m_olane  = g;
      m_count++;
      m_rr = (g + 1) % N;
    end else if (out_ready) begin
      m_ovalid = 0;
    end
    if (m_run && g < 0 && m_count == m_target && pop) begin
      m_run  = 0;
      m_pend = 1;
    end
    m_done = nd;
    if (nd) m_busy = 0;
    if (start && !old_busy) begin
      m_busy   = 1;
      m_target = int'(cfg_num_outputs);
      m_count  = 0;
      if (cfg_num_outputs == '0) m_pend = 1;
      else m_run = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) begin
      case ($urandom % 3)
        0: lane_data[i*DW +: DW] = DW'($urandom);
        1: lane_data[i*DW +: DW] = DW'($urandom_range(0, 40000));
        default: lane_data[i*DW +: DW] = DW'(-int'($urandom_range(0, 40000)));
      endcase
    end
  endtask

  task automatic run_until_idle(input bit randomize_in);
    for (int k = 0; k < 200 && m_busy; k++) begin
      if (randomize_in) begin
        rand_lanes();
        lane_valid = N'($urandom);
        out_ready  = ($urandom % 10) < 7;
      end
      step();
    end
    check_eq("layer_end_busy", 32'(busy), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    model_reset();
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_out_data", 32'(out_data), 32'(0));
    check_eq("rst_out_lane", 32'(out_lane), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_done", 32'(done), 32'(0));
    check_eq("rst_lane_ready", 32'(lane_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [OW-1:0] held_data;
  logic [LW-1:0] held_lane;
  int pops;

  initial begin
    start = 0; cfg_num_outputs = '0; lane_valid = '0; lane_data = '0; out_ready = 1'b0;
    #12;
    do_reset();

    // Single lane, one output.
    lane_data[0 +: DW] = 24'h000500;
    lane_valid = 4'b0001; out_ready = 1'b1; cfg_num_outputs = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("t1_valid", 32'(out_valid), 32'(1));
    check_eq("t1_data", 32'(out_data), 32'(5));
    check_eq("t1_lane", 32'(out_lane), 32'(0));
    lane_valid = '0;
    run_until_idle(0);

    // Negative input then saturation.
    lane_data[0 +: DW] = DW'(-100);
    lane_valid = 4'b0001; cfg_num_outputs = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
`ifdef ACT_LEAKY_RELU_EN
    check_eq("t2_neg", 32'(out_data), 32'(8'hFF));
`else
    check_eq("t2_neg", 32'(out_data), 32'(0));
`endif
    lane_data[0 +: DW] = 24'h7FFFFF;
    step();
    check_eq("t2_sat", 32'(out_data), 32'(127));
    lane_valid = '0;
    run_until_idle(0);

    // Round-robin over all lanes from a fresh pointer, one output per cycle.
    do_reset();
    rand_lanes();
    lane_valid = '1; out_ready = 1'b1; cfg_num_outputs = 16'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("t3_valid", 32'(out_valid), 32'(1));
      check_eq("t3_order", 32'(out_lane), 32'(i % N));
    end
    run_until_idle(0);

    // Backpressure holds the output register and stops grants.
    rand_lanes();
    lane_valid = '1; out_ready = 1'b1; cfg_num_outputs = 16'd6; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    held_data = out_data;
    held_lane = out_lane;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t4_hold_data", 32'(out_data), 32'(held_data));
      check_eq("t4_hold_lane", 32'(out_lane), 32'(held_lane));
    end
    out_ready = 1'b1;
    run_until_idle(0);

    // Zero-length layer: done two cycles after start with no grants.
    lane_valid = '1; cfg_num_outputs = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t5_zero_busy", 32'(busy), 32'(1));
    check_eq("t5_zero_done_early", 32'(done), 32'(0));
    step();
    check_eq("t5_zero_done", 32'(done), 32'(1));
    check_eq("t5_zero_idle", 32'(busy), 32'(0));

    // A start while running must not reload the count.
    lane_valid = '0; cfg_num_outputs = 16'd4; start = 1'b1;
    step();
    cfg_num_outputs = 16'd9;
    step();
    start = 1'b0;
    lane_valid = '1;
    pops = 0;
    for (int k = 0; k < 40 && m_busy; k++) begin
      rand_lanes();
      if (out_valid && out_ready) pops++;
      step();
    end
    check_eq("t5_ignored_start_count", 32'(pops), 32'(4));

    // Reset in the middle of a layer.
    rand_lanes();
    cfg_num_outputs = 16'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    do_reset();
    lane_valid = '0;
    for (int i = 0; i < 4; i++) step();

    // Randomized layers with random backpressure and stray starts.
    for (int l = 0; l < 40; l++) begin
      rand_lanes();
      lane_valid = N'($urandom);
      out_ready  = ($urandom % 10) < 7;
      cfg_num_outputs = CW'($urandom_range(0, 12));
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 200 && m_busy; k++) begin
        rand_lanes();
        lane_valid = N'($urandom);
        out_ready  = ($urandom % 10) < 7;
        start = ($urandom % 16) == 0;
        cfg_num_outputs = CW'($urandom_range(0, 12));
        step();
        start = 1'b0;
      end
      check_eq("rand_layer_end_busy", 32'(busy), 32'(0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
